seg7_scan_disp: RTL and testbench

//  Successor to the single-digit SEG7DEC: drives a DIGITS-wide multiplexed 7-seg display from a binary value.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_nib_dec.sv | 13 +
 rtl/seg7_scan_disp.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_disp.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, FSM encoding and the 7-segment glyph table
// for the multiplexed display driver.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } state_t;

    // Active-low {g,f,e,d,c,b,a}; codes 10-15 cannot survive conversion and show blank.
    function automatic logic [6:0] seg7_pat(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_nib_dec.sv
// Combinational BCD nibble to active-low segment pattern.
module seg7_nib_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg7_pat(nib);
    end

endmodule

// File: rtl/seg7_scan_disp.sv
// Binary-to-BCD (double-dabble) converter feeding a time-multiplexed
// active-low 7-segment scanner with leading-zero blanking and overflow dashes.
module seg7_scan_disp
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIN_W    = 14,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DIN_W-1:0]  DIN,
    input  logic              LOAD,
    output logic              BUSY,
    output logic              OVF,
    output logic [6:0]        nHEX,
    output logic [DIGITS-1:0] nAN
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIN_W + 1);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam longint unsigned MAX_VAL = longint'(10 ** DIGITS) - 1;

    state_t             state, state_nxt;
    logic [DIN_W-1:0]   bin_q;
    logic [BCD_W-1:0]   bcd_q, bcd_adj, disp_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_pend;

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (LOAD) state_nxt = ST_CONV;
            ST_CONV: if (cnt_q == CNT_W'(1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state != ST_IDLE);
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // The display register only changes in DONE, so partial BCD never reaches the pins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_pend <= 1'b0;
            OVF      <= 1'b0;
            disp_q   <= '1;
        end else begin
            case (state)
                ST_IDLE: if (LOAD) begin
                    bin_q    <= DIN;
                    bcd_q    <= '0;
                    cnt_q    <= CNT_W'(DIN_W);
                    ovf_pend <= (64'(DIN) > MAX_VAL);
                end
                ST_CONV: begin
                    {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                    cnt_q          <= cnt_q - CNT_W'(1);
                end
                ST_DONE: begin
                    disp_q <= bcd_q;
                    OVF    <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

    logic [PRE_W-1:0]  presc_q;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic              wrap;
    logic [DIGITS-1:0] upper_zero;
    logic              zero_run;
    logic [3:0]        sel_nib;
    logic [6:0]        dec_seg, seg_nxt;

    always_comb begin
        wrap    = (presc_q == PRE_W'(SCAN_DIV - 1));
        idx_nxt = idx_q;
        if (wrap) idx_nxt = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // upper_zero[k]: digit k and every digit above it are zero.
    always_comb begin
        zero_run   = 1'b1;
        upper_zero = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            zero_run = zero_run & (disp_q[4*(DIGITS-1-i) +: 4] == 4'd0);
            upper_zero[DIGITS-1-i] = zero_run;
        end
    end

    always_comb begin
        sel_nib = disp_q[4*idx_nxt +: 4];
    end

    seg7_nib_dec u_dec (
        .nib (sel_nib),
        .seg (dec_seg)
    );

    always_comb begin
        if (OVF)
            seg_nxt = SEG_DASH;
        else if ((BLANK_LZ != 0) && (idx_nxt != '0) && upper_zero[idx_nxt])
            seg_nxt = SEG_BLANK;
        else
            seg_nxt = dec_seg;
    end

    // Outputs are driven from the next index so anode and segments switch on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q <= '0;
            idx_q   <= '0;
            nHEX    <= SEG_BLANK;
            nAN     <= '1;
        end else begin
            presc_q <= wrap ? '0 : presc_q + PRE_W'(1);
            idx_q   <= idx_nxt;
            nHEX    <= seg_nxt;
            nAN     <= ~(DIGITS'(1) << idx_nxt);
        end
    end

endmodule

// File: tb/tb_seg7_scan_disp.sv
// Directed self-checking bench for seg7_scan_disp (4 digits, 14-bit input, fast scan).
module tb_seg7_scan_disp;

    logic        clk, rst, load;
    logic [13:0] din;
    logic        busy, ovf, busy2, ovf2;
    logic [6:0]  nhex, nhex2;
    logic [3:0]  nan, nan2;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P7 = 7'b1111000, P9 = 7'b0010000;
    localparam logic [6:0] PB = 7'b1111111, PD = 7'b0111111;

    seg7_scan_disp #(.DIGITS(4), .DIN_W(14), .SCAN_DIV(4), .BLANK_LZ(1)) dut (
        .CLK(clk), .RST(rst), .DIN(din), .LOAD(load),
        .BUSY(busy), .OVF(ovf), .nHEX(nhex), .nAN(nan)
    );

    seg7_scan_disp #(.DIGITS(4), .DIN_W(14), .SCAN_DIV(4), .BLANK_LZ(0)) dut_nolz (
        .CLK(clk), .RST(rst), .DIN(din), .LOAD(load),
        .BUSY(busy2), .OVF(ovf2), .nHEX(nhex2), .nAN(nan2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [13:0] v);
        din  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic check_digit(input string tag, input bit alt, input int k, input logic [6:0] exp);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << k);
        n = 0;
        @(negedge clk);
        while (((alt ? nan2 : nan) !== want) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_an"}, 16'(alt ? nan2 : nan), 16'(want));
        check(tag, 16'(alt ? nhex2 : nhex), 16'(exp));
    endtask

    initial begin
        int cyc;
        rst  = 1'b1;
        load = 1'b0;
        din  = '0;
        repeat (3) @(negedge clk);
        check("rst_nhex", 16'(nhex), 16'(PB));
        check("rst_nan",  16'(nan),  16'hF);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_ovf",  16'(ovf),  16'h0);
        rst = 1'b0;
        @(negedge clk);
        check("first_nan", 16'(nan), 16'hE);

        do_load(14'd1234);
        wait_idle(cyc);
        check("busy_len", 16'(cyc), 16'd15);
        check("ovf_1234", 16'(ovf), 16'h0);
        check_digit("d0_1234", 1'b0, 0, P4);
        check_digit("d1_1234", 1'b0, 1, P3);
        check_digit("d2_1234", 1'b0, 2, P2);
        check_digit("d3_1234", 1'b0, 3, P1);

        do_load(14'd7);
        wait_idle(cyc);
        check_digit("d0_7", 1'b0, 0, P7);
        check_digit("d1_7", 1'b0, 1, PB);
        check_digit("d2_7", 1'b0, 2, PB);
        check_digit("d3_7", 1'b0, 3, PB);
        check_digit("nolz_d0_7", 1'b1, 0, P7);
        check_digit("nolz_d1_7", 1'b1, 1, P0);
        check_digit("nolz_d3_7", 1'b1, 3, P0);

        do_load(14'd0);
        wait_idle(cyc);
        check_digit("d0_0", 1'b0, 0, P0);
        check_digit("d1_0", 1'b0, 1, PB);
        check_digit("d3_0", 1'b0, 3, PB);

        do_load(14'd12000);
        wait_idle(cyc);
        check("ovf_set", 16'(ovf), 16'h1);
        check_digit("d0_ovf", 1'b0, 0, PD);
        check_digit("d1_ovf", 1'b0, 1, PD);
        check_digit("d2_ovf", 1'b0, 2, PD);
        check_digit("d3_ovf", 1'b0, 3, PD);

        do_load(14'd9999);
        wait_idle(cyc);
        check("ovf_clr", 16'(ovf), 16'h0);
        check_digit("d0_9999", 1'b0, 0, P9);
        check_digit("d3_9999", 1'b0, 3, P9);

        // Old value (all nines) must hold while converting; the LOAD of 42 lands mid-conversion.
        do_load(14'd1234);
        for (int i = 1; i <= 13; i++) begin
            check("hold_9999", 16'(nhex), 16'(P9));
            if (i == 4) begin
                din  = 14'd42;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        wait_idle(cyc);
        check_digit("d0_ign42", 1'b0, 0, P4);
        check_digit("d1_ign42", 1'b0, 1, P3);
        check_digit("d2_ign42", 1'b0, 2, P2);
        check_digit("d3_ign42", 1'b0, 3, P1);

        do_load(14'd1234);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 16'(busy), 16'h0);
        check("abort_nan",  16'(nan),  16'hF);
        check("abort_nhex", 16'(nhex), 16'(PB));
        check("abort_ovf",  16'(ovf),  16'h0);
        check_digit("d0_abort", 1'b0, 0, PB);
        check_digit("d1_abort", 1'b0, 1, PB);
        check("abort_idle", 16'(busy), 16'h0);

        do_load(14'd55);
        wait_idle(cyc);
        check("busy_len55", 16'(cyc), 16'd15);
        check_digit("d0_55", 1'b0, 0, P5);
        check_digit("d1_55", 1'b0, 1, P5);
        check_digit("d2_55", 1'b0, 2, PB);
        check_digit("d3_55", 1'b0, 3, PB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
